// File: rtl/stopwatch_pkg.sv
// Shared types, constants and the 7-segment encoder for the multi-digit stopwatch.
// Segment codes are active-high, bit order gfedcba.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_encode(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch counter: up/down step with a combinational
// wrap output that feeds the enable of the next digit in the same cycle.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       wrap
);

  bcd_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      // Non-BCD presets saturate to 9.
      value_d = (load_val > BCD_MAX) ? BCD_MAX : load_val;
    end else if (en) begin
      if (up) begin
        value_d = (value_q == BCD_MAX) ? 4'd0 : value_q + 4'd1;
      end else begin
        value_d = (value_q == 4'd0) ? BCD_MAX : value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign wrap  = en & (up ? (value_q == BCD_MAX) : (value_q == 4'd0));

endmodule

// File: rtl/stopwatch_multi.sv
// N-digit BCD stopwatch / countdown timer with tick prescaler, preset load and
// lap-hold display, driving one registered 7-segment code per digit.
module stopwatch_multi
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    mode,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    lap,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    running,
  output logic                    done
);

  localparam int unsigned PresW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CountW = 4 * NUM_DIGITS;

  logic [PresW-1:0]        presc_q, presc_d;
  logic                    running_q, done_q, done_d, hold_q, hold_d;
  logic [CountW-1:0]       count, disp_q, disp;
  logic [7*NUM_DIGITS-1:0] segs_q, segs_d;
  logic [NUM_DIGITS-1:0]   en, wrap;
  logic                    tick, step, count_zero, count_one;
  logic                    unused_wrap;

  assign tick       = running_q && (presc_q == PresW'(TICK_DIV - 1));
  assign count_zero = (count == '0);
  assign count_one  = (count == CountW'(1));
  // Down-counting stops at zero instead of underflowing to all-9s.
  assign step       = tick & ~load & ~(mode & count_zero);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign en[k] = step;
    end else begin : g_chain
      assign en[k] = wrap[k-1];
    end

    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .en       (en[k]),
      .up       (~mode),
      .load     (load),
      .load_val (load_value[4*k +: 4]),
      .value    (count[4*k +: 4]),
      .wrap     (wrap[k])
    );
  end

  assign unused_wrap = wrap[NUM_DIGITS-1];

  // The display source is chosen combinationally so segs lag count by one clk.
  assign disp = hold_q ? disp_q : count;

  always_comb begin
    presc_d = presc_q;
    done_d  = done_q;
    hold_d  = hold_q ^ lap;
    if (load) begin
      presc_d = '0;
      done_d  = 1'b0;
      hold_d  = 1'b0;
    end else begin
      if (running_q) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (!mode) begin
        done_d = 1'b0;
      end else if (tick && (count_zero || count_one)) begin
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    segs_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      segs_d[7*k +: 7] = seg_encode(disp[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= 1'b0;
      disp_q    <= '0;
      segs_q    <= {NUM_DIGITS{SEG_0}};
    end else begin
      presc_q   <= presc_d;
      running_q <= start_stop & ~done_q;
      done_q    <= done_d;
      hold_q    <= hold_d;
      disp_q    <= disp;
      segs_q    <= segs_d;
    end
  end

  assign segs    = segs_q;
  assign running = running_q;
  assign done    = done_q;

endmodule
